// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO control slice that fronts sync_mem.
//   AW_DEF / DW_DEF : default address and data widths (match sync_mem)
//   DEPTH           : number of storage entries for the default build
//   ptr_t           : wrap-bit pointer type (one bit wider than an address)
//   data_t          : one storage word
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int DEPTH  = 2 ** AW_DEF;

    typedef logic [AW_DEF:0]   ptr_t;
    typedef logic [DW_DEF-1:0] data_t;

endpackage

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// Wrap-bit pointer counter. The low AW bits address the storage array and
// the extra MSB toggles on every pass through the array, which lets the
// parent tell a full FIFO from an empty one when the addresses match.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointer -> 0)
//   inc    in   advance the pointer by one on this edge
//   ptr    out  AW+1 bit pointer value
// ---------------------------------------------------------------------------
module fifo_ptr #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [AW:0] ptr
);

    // Natural binary rollover of the AW+1 bit value gives the required
    // behaviour: low bits wrap to 0 and the MSB toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Single-clock FIFO control stage for the dual-port sync_mem array. Owns the
// write/read pointers and status flags, drives the memory write port and
// read address, and presents the memory's combinational read data as
// first-word-fall-through head data.
// Build option:
//   FIFO_CTRL_ERR_EN  when defined, overflow/underflow are sticky error
//                     flags cleared by err_clr; otherwise both are tied 0.
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   wr_en, wr_data                producer push request and data
//   full, almost_full             occupancy == 2^AW / occupancy >= AF_LEVEL
//   rd_en, rd_data                consumer pop request, head-of-FIFO data
//   empty, almost_empty           occupancy == 0 / occupancy <= AE_LEVEL
//   count                         current occupancy, 0..2^AW
//   err_clr, overflow, underflow  sticky error flags and their clear
//   mem_a1, mem_wd1, mem_we1      sync_mem write port
//   mem_a2, mem_rd2               sync_mem read address / read data
// ---------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int AF_LEVEL = 252,
    parameter int AE_LEVEL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          almost_full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   count,
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow,
    output logic [AW-1:0] mem_a1,
    output logic [DW-1:0] mem_wd1,
    output logic          mem_we1,
    output logic [AW-1:0] mem_a2,
    input  logic [DW-1:0] mem_rd2
);

    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        pop;

    // Equal pointers mean empty; equal addresses on opposite laps mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // rst_n is folded in so the memory write strobe is dead during reset
    // even if the producer keeps wr_en high.
    assign push = wr_en & ~full  & rst_n;
    assign pop  = rd_en & ~empty & rst_n;

    // Modular difference of the wrap-bit pointers is the occupancy; it can
    // never leave 0..2^AW because full/empty gate the increments.
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    assign mem_a1  = wr_ptr[AW-1:0];
    assign mem_wd1 = wr_data;
    assign mem_we1 = push;
    assign mem_a2  = rd_ptr[AW-1:0];
    assign rd_data = mem_rd2;

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

`ifdef FIFO_CTRL_ERR_EN
    // Sticky error flags. A new violation in the same cycle as err_clr
    // keeps the flag set so no event is ever silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    // Error reporting compiled out; err_clr has no function in this build.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
